// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE result, runs the data-memory request FSM,
// aligns and extends load data, and drives WB and the decode forwarding/stall signals.
// Optional build macro MEM_MISALIGN_CHECK_EN adds misaligned-access suppression and the mem_misalign port.
module mem_stage #(
  parameter int EXE_TO_MEM_WIDTH = 171,
  parameter int MEM_TO_WB_WIDTH  = 102
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        exe_to_mem_valid,
  output logic                        mem_allowin,
  input  logic [EXE_TO_MEM_WIDTH-1:0] exe_to_mem_bus,
  output logic                        mem_to_wb_valid,
  input  logic                        wb_allowin,
  output logic [MEM_TO_WB_WIDTH-1:0]  mem_to_wb_bus,
  output logic                        dmem_req_valid,
  input  logic                        dmem_req_ready,
  output logic                        dmem_req_wen,
  output logic [63:0]                 dmem_addr,
  output logic [63:0]                 dmem_wdata,
  output logic [7:0]                  dmem_wstrb,
  input  logic                        dmem_resp_valid,
  input  logic [63:0]                 dmem_resp_rdata,
  output logic                        mem_fwd_wen,
  output logic [4:0]                  mem_fwd_rd,
  output logic [63:0]                 mem_fwd_data,
  output logic                        mem_fwd_pending
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                        mem_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                      state, state_nxt;
  logic                        mem_valid;
  logic [EXE_TO_MEM_WIDTH-1:0] bus_r;
  logic [63:0]                 load_res;

  logic [31:0] pc;
  logic        rd_wen;
  logic [4:0]  rd;
  logic [63:0] alu_res;
  logic        mem_ren, mem_wen, mem_uns;
  logic [1:0]  mem_size;
  logic [63:0] st_data;

  assign pc       = bus_r[170:139];
  assign rd_wen   = bus_r[138];
  assign rd       = bus_r[137:133];
  assign alu_res  = bus_r[132:69];
  assign mem_ren  = bus_r[68];
  assign mem_wen  = bus_r[67];
  assign mem_size = bus_r[66:65];
  assign mem_uns  = bus_r[64];
  assign st_data  = bus_r[63:0];

  logic       is_mem, ready_go, misalign;
  logic [2:0] off;
  logic [5:0] shamt;

  assign is_mem = mem_ren | mem_wen;
  assign off    = alu_res[2:0];
  assign shamt  = {off, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  logic [2:0] align_mask;
  always_comb begin
    align_mask = 3'b000;
    case (mem_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end
  assign misalign     = is_mem && ((off & align_mask) != 3'b000);
  assign mem_misalign = mem_valid && misalign;
`else
  assign misalign = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where both valid and
  // ready (allowin) are high; valid and its payload stay stable until then.
  assign ready_go        = is_mem ? (state == DONE) : 1'b1;
  assign mem_allowin     = !mem_valid || (ready_go && wb_allowin);
  assign mem_to_wb_valid = mem_valid && ready_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      state     <= IDLE;
    end else begin
      state <= state_nxt;
      if (mem_allowin) mem_valid <= exe_to_mem_valid;
    end
  end

  logic [63:0] raw, load_ext;

  always_ff @(posedge clk) begin
    if (exe_to_mem_valid && mem_allowin) bus_r <= exe_to_mem_bus;
    if (state == RESP && dmem_resp_valid && mem_ren) load_res <= load_ext;
  end

  always_comb begin
    state_nxt      = state;
    dmem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid && is_mem) begin
          if (misalign) begin
            state_nxt = DONE;
          end else begin
            dmem_req_valid = 1'b1;
            state_nxt      = dmem_req_ready ? RESP : REQ;
          end
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = RESP;
      end
      RESP: if (dmem_resp_valid) state_nxt = DONE;
      DONE: if (wb_allowin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [7:0] strb_base;
  always_comb begin
    strb_base = 8'h01;
    case (mem_size)
      2'd0: strb_base = 8'h01;
      2'd1: strb_base = 8'h03;
      2'd2: strb_base = 8'h0F;
      2'd3: strb_base = 8'hFF;
      default: strb_base = 8'h01;
    endcase
  end

  assign dmem_req_wen = mem_wen;
  assign dmem_addr    = alu_res;
  assign dmem_wdata   = st_data << shamt;
  assign dmem_wstrb   = strb_base << off;

  assign raw = dmem_resp_rdata >> shamt;
  always_comb begin
    load_ext = raw;
    case (mem_size)
      2'd0: load_ext = mem_uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'd1: load_ext = mem_uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2: load_ext = mem_uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      2'd3: load_ext = raw;
      default: load_ext = raw;
    endcase
  end

  // A suppressed (misaligned) load never captured data, so it reports its address instead.
  logic        out_rd_wen, use_load;
  logic [63:0] wdata_out;
  assign use_load   = mem_ren && !misalign;
  assign out_rd_wen = rd_wen && !mem_wen && !misalign;
  assign wdata_out  = use_load ? load_res : alu_res;

  assign mem_to_wb_bus   = {pc, out_rd_wen, rd, wdata_out};
  assign mem_fwd_wen     = mem_valid && out_rd_wen && (rd != 5'd0);
  assign mem_fwd_rd      = rd;
  assign mem_fwd_data    = (use_load && state == DONE) ? load_res : alu_res;
  assign mem_fwd_pending = mem_valid && mem_ren && (state != DONE);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver tasks push expected WB payloads into a queue,
// a negedge monitor pops and compares them on every accepted WB transfer.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         exe_to_mem_valid;
  logic         mem_allowin;
  logic [170:0] exe_to_mem_bus;
  logic         mem_to_wb_valid;
  logic         wb_allowin;
  logic [101:0] mem_to_wb_bus;
  logic         dmem_req_valid;
  logic         dmem_req_ready;
  logic         dmem_req_wen;
  logic [63:0]  dmem_addr;
  logic [63:0]  dmem_wdata;
  logic [7:0]   dmem_wstrb;
  logic         dmem_resp_valid;
  logic [63:0]  dmem_resp_rdata;
  logic         mem_fwd_wen;
  logic [4:0]   mem_fwd_rd;
  logic [63:0]  mem_fwd_data;
  logic         mem_fwd_pending;
`ifdef MEM_MISALIGN_CHECK_EN
  logic         mem_misalign;
`endif

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
    .exe_to_mem_bus(exe_to_mem_bus),
    .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .mem_to_wb_bus(mem_to_wb_bus),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_wen(dmem_req_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .mem_fwd_wen(mem_fwd_wen), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .mem_fwd_pending(mem_fwd_pending)
`ifdef MEM_MISALIGN_CHECK_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [101:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder: answers one cycle after each accepted request
  logic        fire_seen = 1'b0;
  logic        resp_enable = 1'b1;
  logic        late_resp = 1'b0;
  logic [63:0] mem_rdata = 64'd0;
  int          fire_count = 0;

  always @(negedge clk) begin
    fire_seen = dmem_req_valid && dmem_req_ready && !rst;
    if (fire_seen) fire_count++;
  end

  always @(posedge clk) begin
    #1;
    dmem_resp_valid = (fire_seen && resp_enable) || late_resp;
    dmem_resp_rdata = mem_rdata;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && mem_to_wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got %h expected no transfer", mem_to_wb_bus);
      end else begin
        check("wb_bus", mem_to_wb_bus, exp_q.pop_front());
      end
    end
  end

  function automatic logic [170:0] mk_in(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                                         input logic [63:0] alu, input logic ren, input logic wen,
                                         input logic [1:0] sz, input logic uns, input logic [63:0] st);
    return {pc, rw, rd, alu, ren, wen, sz, uns, st};
  endfunction

  function automatic logic [101:0] mk_out(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                                          input logic [63:0] wd);
    return {pc, rw, rd, wd};
  endfunction

  // driver: returns at posedge+1 of the entry edge (first cycle in the stage)
  task automatic send(input logic [170:0] b, input logic [101:0] e, input bit push);
    int w;
    exe_to_mem_bus   = b;
    exe_to_mem_valid = 1'b1;
    w = 0;
    while (!mem_allowin && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("allowin_wait", mem_allowin, 1'b1);
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
  endtask

  task automatic wait_out(input int max_cyc, output int n);
    n = 1;
    while (!mem_to_wb_valid && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_timeout", mem_to_wb_valid, 1'b1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int           n;
  int           fc0;
  logic [63:0]  a0, d0;
  logic [101:0] b0;

  initial begin
    rst = 1'b1; exe_to_mem_valid = 1'b0; exe_to_mem_bus = '0;
    wb_allowin = 1'b1; dmem_req_ready = 1'b1;
    dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_valid", mem_to_wb_valid, 1'b0);
    check("rst_req_valid", dmem_req_valid, 1'b0);
    check("rst_fwd_wen", mem_fwd_wen, 1'b0);
    check("rst_fwd_pending", mem_fwd_pending, 1'b0);
    check("rst_allowin", mem_allowin, 1'b1);
    rst = 1'b0;
    step();

    // ADD passthrough
    send(mk_in(32'h80000000, 1, 5, 64'h1234, 0, 0, 0, 0, 0),
         mk_out(32'h80000000, 1, 5, 64'h1234), 1);
    wait_out(10, n);
    check("add_latency", n, 1);
    check("add_no_req", dmem_req_valid, 1'b0);
    check("add_fwd_wen", mem_fwd_wen, 1'b1);
    check("add_fwd_data", mem_fwd_data, 64'h1234);
    step();

    // LB / LBU at 0x1003
    mem_rdata = 64'h00000000_80000000;
    send(mk_in(32'h80000004, 1, 6, 64'h1003, 1, 0, 0, 0, 0),
         mk_out(32'h80000004, 1, 6, 64'hFFFFFFFF_FFFFFF80), 1);
    check("lb_req_valid", dmem_req_valid, 1'b1);
    check("lb_addr", dmem_addr, 64'h1003);
    check("lb_req_wen", dmem_req_wen, 1'b0);
    check("lb_pending", mem_fwd_pending, 1'b1);
    wait_out(10, n);
    check("lb_latency", n, 3);
    check("lb_pending_done", mem_fwd_pending, 1'b0);
    check("lb_fwd_data", mem_fwd_data, 64'hFFFFFFFF_FFFFFF80);
    step();

    send(mk_in(32'h80000008, 1, 6, 64'h1003, 1, 0, 0, 1, 0),
         mk_out(32'h80000008, 1, 6, 64'h80), 1);
    wait_out(10, n);
    check("lbu_latency", n, 3);
    step();

    // SH at 0x2006
    send(mk_in(32'h8000000C, 1, 7, 64'h2006, 0, 1, 1, 0, 64'hBEEF),
         mk_out(32'h8000000C, 0, 7, 64'h2006), 1);
    check("sh_wstrb", dmem_wstrb, 8'hC0);
    check("sh_wdata", dmem_wdata, 64'hBEEF0000_00000000);
    check("sh_req_wen", dmem_req_wen, 1'b1);
    wait_out(10, n);
    check("sh_latency", n, 3);
    step();

    // LD with request ready low for 4 cycles
    mem_rdata = 64'h11223344_55667788;
    dmem_req_ready = 1'b0;
    send(mk_in(32'h80000010, 1, 8, 64'h3000, 1, 0, 3, 0, 64'hAA),
         mk_out(32'h80000010, 1, 8, 64'h11223344_55667788), 1);
    a0 = dmem_addr;
    d0 = dmem_wdata;
    check("stall_addr0", a0, 64'h3000);
    check("stall_wdata0", d0, 64'hAA);
    for (int i = 0; i < 4; i++) begin
      check("stall_req_valid", dmem_req_valid, 1'b1);
      check("stall_addr", dmem_addr, a0);
      check("stall_wdata", dmem_wdata, d0);
      check("stall_allowin", mem_allowin, 1'b0);
      check("stall_pending", mem_fwd_pending, 1'b1);
      if (i < 3) step();
    end
    dmem_req_ready = 1'b1;
    wait_out(10, n);
    check("stall_pending_done", mem_fwd_pending, 1'b0);
    step();

    // LW in DONE with WB back-pressure
    mem_rdata = 64'h87654321_00000000;
    wb_allowin = 1'b0;
    fc0 = fire_count;
    send(mk_in(32'h80000014, 1, 9, 64'h1004, 1, 0, 2, 0, 0),
         mk_out(32'h80000014, 1, 9, 64'hFFFFFFFF_87654321), 1);
    wait_out(10, n);
    b0 = mem_to_wb_bus;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", mem_to_wb_valid, 1'b1);
      check("bp_bus", mem_to_wb_bus, b0);
      check("bp_no_req", dmem_req_valid, 1'b0);
    end
    check("bp_fire_count", fire_count - fc0, 1);
    wb_allowin = 1'b1;
    step();

    // reset while waiting in RESP, then a late response
    resp_enable = 1'b0;
    send(mk_in(32'h80000018, 1, 10, 64'h4000, 1, 0, 3, 0, 0), '0, 0);
    step();
    check("rsp_pending", mem_fwd_pending, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_wb_valid", mem_to_wb_valid, 1'b0);
    check("mrst_req_valid", dmem_req_valid, 1'b0);
    check("mrst_fwd_wen", mem_fwd_wen, 1'b0);
    check("mrst_pending", mem_fwd_pending, 1'b0);
    check("mrst_allowin", mem_allowin, 1'b1);
    late_resp = 1'b1;
    step();
    late_resp = 1'b0;
    resp_enable = 1'b1;
    repeat (3) begin
      step();
      check("late_wb_valid", mem_to_wb_valid, 1'b0);
      check("late_req_valid", dmem_req_valid, 1'b0);
    end

    // recovery
    send(mk_in(32'h8000001C, 1, 11, 64'h5555, 0, 0, 0, 0, 0),
         mk_out(32'h8000001C, 1, 11, 64'h5555), 1);
    wait_out(10, n);
    check("post_rst_latency", n, 1);
    step();

`ifdef MEM_MISALIGN_CHECK_EN
    send(mk_in(32'h80000040, 1, 12, 64'h1002, 1, 0, 2, 0, 0),
         mk_out(32'h80000040, 0, 12, 64'h1002), 1);
    check("mis_no_req", dmem_req_valid, 1'b0);
    check("mis_flag", mem_misalign, 1'b1);
    wait_out(10, n);
    check("mis_latency", n, 2);
    step();
    check("mis_flag_clear", mem_misalign, 1'b0);
`endif

    repeat (2) step();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
